wb_i2s_dma: RTL and testbench

//  Wishbone bus-master DMA that keeps the I2S transmitter FIFO fed from a ring buffer in memory.
//  - Refill trigger: the I2S half-FIFO refill interrupt (req_i).
//  - Per refill: moves BURST 32-bit words. Each word is one memory read followed by one write
//    to the I2S data register.
//  - Sits between the system Wishbone interconnect and the I2S peripheral; the CPU only

---
 rtl/wb_i2s_dma.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_i2s_dma.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_i2s_dma.sv
// wb_i2s_dma
// Wishbone bus-master DMA that keeps the I2S transmitter FIFO fed from a
// ring buffer in memory. Each refill request moves BURST words. Each word is
// one memory read followed by one write to the I2S data register.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   s_cyc_i .. s_dat_o    configuration slave: 0 CTRL, 1 BASE, 2 LEN, 3 STAT
//   m_cyc_o .. m_dat_i    bus master towards memory and the I2S data register
//   req_i                 I2S half-FIFO refill request (level, rising edge counted)
//   irq_o                 ring-position interrupt to the CPU (half / wrap)
module wb_i2s_dma #(
    parameter int unsigned BURST    = 2048,
    parameter int unsigned PRIME    = 2,
    parameter logic [31:0] I2S_ADDR = 32'h4000_0004
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic [1:0]  s_adr_i,
    input  logic        s_we_i,
    input  logic [31:0] s_dat_i,
    output logic        s_ack_o,
    output logic [31:0] s_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i,
    input  logic        req_i,
    output logic        irq_o
);

    localparam logic [15:0] LAST_CNT = 16'(BURST - 1);
    localparam logic [1:0]  PRIME_W  = 2'(PRIME);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  ctrl;
    logic [31:0] base;
    logic [15:0] len;
    logic [15:0] pos;
    logic [15:0] cnt;
    logic [1:0]  pend;
    logic        wrap_f;
    logic        half_f;
    logic        req_q;
    logic [31:0] rd_buf;

    logic        en;
    logic        busy;
    logic        acc;
    logic        wr_acc;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        en_rise;
    logic        req_rise;
    logic        start;
    logic        rd_done;
    logic        wr_done;
    logic        pos_last;
    logic        pos_half;
    logic [15:0] len_m1;
    logic [15:0] half_m1;

    assign en       = ctrl[0];
    assign busy     = (state != IDLE);
    assign acc      = s_cyc_i & s_stb_i & ~s_ack_o;
    assign wr_acc   = acc & s_we_i;
    assign wr_ctrl  = wr_acc & (s_adr_i == 2'd0);
    assign wr_stat  = wr_acc & (s_adr_i == 2'd3);
    assign en_rise  = wr_ctrl & s_dat_i[0] & ~en;
    assign req_rise = req_i & ~req_q;

    // For LEN==1, half_m1 is 16'hFFFF, which pos never reaches, so half_f stays clear.
    assign len_m1   = len - 16'd1;
    assign half_m1  = {1'b0, len[15:1]} - 16'd1;
    assign pos_last = (pos == len_m1);
    assign pos_half = (pos == half_m1);

    // Slave port: one ack per access. A write lands on the edge that raises
    // the ack, and read data is captured on that same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s_ack_o <= 1'b0;
            s_dat_o <= 32'd0;
            ctrl    <= 3'd0;
            base    <= 32'd0;
            len     <= 16'd0;
        end else begin
            s_ack_o <= acc;
            if (acc) begin
                case (s_adr_i)
                    2'd0:    s_dat_o <= {29'd0, ctrl};
                    2'd1:    s_dat_o <= base;
                    2'd2:    s_dat_o <= {16'd0, len};
                    default: s_dat_o <= {busy, 1'b0, wrap_f, half_f, 12'd0, pos};
                endcase
            end
            if (wr_acc) begin
                case (s_adr_i)
                    2'd0:    ctrl <= s_dat_i[2:0];
                    2'd1:    base <= {s_dat_i[31:2], 2'b00};
                    2'd2:    len  <= s_dat_i[15:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are held until ack. After the read ack the FSM goes straight into
    // the write, with no idle cycle. Clearing en ends the burst at the next ack.
    always_comb begin
        state_nxt = state;
        m_cyc_o   = 1'b0;
        m_stb_o   = 1'b0;
        m_we_o    = 1'b0;
        m_adr_o   = 32'd0;
        m_dat_o   = 32'd0;
        m_sel_o   = 4'h0;
        start     = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: begin
                if (en && (pend != 2'd0) && (len != 16'd0)) begin
                    start     = 1'b1;
                    state_nxt = RD;
                end
            end
            RD: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_sel_o = 4'hF;
                m_adr_o = base + {14'd0, pos, 2'b00};
                if (m_ack_i) begin
                    rd_done   = 1'b1;
                    state_nxt = en ? WR : IDLE;
                end
            end
            WR: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_sel_o = 4'hF;
                m_adr_o = I2S_ADDR;
                m_dat_o = rd_buf;
                if (m_ack_i) begin
                    wr_done   = 1'b1;
                    state_nxt = ((cnt == LAST_CNT) || !en) ? IDLE : RD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending-burst counter. Enabling loads the prime count, and a disabled
    // block holds nothing pending. A request edge that coincides with a burst
    // start cancels out.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_q <= 1'b0;
            pend  <= 2'd0;
        end else begin
            req_q <= req_i;
            if (en_rise) begin
                pend <= PRIME_W;
            end else if (!en) begin
                pend <= 2'd0;
            end else if (req_rise && !start) begin
                if (pend != 2'd3) begin
                    pend <= pend + 2'd1;
                end
            end else if (!req_rise && start) begin
                pend <= pend - 2'd1;
            end
        end
    end

    // Ring position, burst word count and read buffer. pos moves only when a
    // word reaches the I2S, so an aborted read leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pos    <= 16'd0;
            cnt    <= 16'd0;
            rd_buf <= 32'd0;
        end else begin
            if (rd_done) begin
                rd_buf <= m_dat_i;
            end
            if (en_rise) begin
                pos <= 16'd0;
                cnt <= 16'd0;
            end else begin
                if (start) begin
                    cnt <= 16'd0;
                end
                if (wr_done) begin
                    pos <= pos_last ? 16'd0 : pos + 16'd1;
                    if (state_nxt == RD) begin
                        cnt <= cnt + 16'd1;
                    end
                end
            end
        end
    end

    // Ring-position flags. If a set and a clear fall on the same cycle, the set wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wrap_f <= 1'b0;
            half_f <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            wrap_f <= (wr_done & pos_last) | (wrap_f & ~(wr_stat & s_dat_i[29]));
            half_f <= (wr_done & pos_half) | (half_f & ~(wr_stat & s_dat_i[28]));
            irq_o  <= (ctrl[1] & half_f) | (ctrl[2] & wrap_f);
        end
    end

endmodule

// File: tb/tb_wb_i2s_dma.sv
// tb_wb_i2s_dma
// Self-checking bench for wb_i2s_dma. A memory model answers master reads,
// and a monitor follows the ring at word level (address = BASE + 4*pos, with
// pos advanced modulo LEN). Register access is table-driven. Multi-cycle
// scenarios (prime, refill, saturation, wrap, disable, reset) are written by hand.
module tb_wb_i2s_dma;

    localparam logic [31:0] I2S_ADDR = 32'h4000_0004;
    localparam int          BURST    = 2048;
    localparam logic [1:0]  A_CTRL   = 2'd0;
    localparam logic [1:0]  A_BASE   = 2'd1;
    localparam logic [1:0]  A_LEN    = 2'd2;
    localparam logic [1:0]  A_STAT   = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        s_cyc_i = 1'b0;
    logic        s_stb_i = 1'b0;
    logic [1:0]  s_adr_i = 2'd0;
    logic        s_we_i = 1'b0;
    logic [31:0] s_dat_i = 32'd0;
    logic        s_ack_o;
    logic [31:0] s_dat_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;
    logic        req_i = 1'b0;
    logic        irq_o;

    always #5 clk_i = ~clk_i;

    wb_i2s_dma dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .s_cyc_i (s_cyc_i),
        .s_stb_i (s_stb_i),
        .s_adr_i (s_adr_i),
        .s_we_i  (s_we_i),
        .s_dat_i (s_dat_i),
        .s_ack_o (s_ack_o),
        .s_dat_o (s_dat_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_sel_o (m_sel_o),
        .m_ack_i (m_ack_i),
        .m_dat_i (m_dat_i),
        .req_i   (req_i),
        .irq_o   (irq_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem_seed = 32'd0;

    // Reference model state: configuration, ring position and flags.
    logic [31:0] base_m = 32'd0;
    int          len_m  = 0;
    int          pos_m  = 0;
    logic [2:0]  ctrl_m = 3'd0;
    logic        wrap_m = 1'b0;
    logic        half_m = 1'b0;

    int          wr_count    = 0;
    int          cyc_cycles  = 0;
    int          wrap_seen   = 0;
    logic [31:0] rd_data_m   = 32'd0;
    logic        rd_valid    = 1'b0;
    logic        hold_valid  = 1'b0;
    logic [31:0] hold_adr    = 32'd0;
    logic        hold_we     = 1'b0;
    logic [31:0] last_rd_adr = 32'hFFFF_FFFF;

    int wait_cnt    = 0;
    int cur_delay   = 0;
    int fixed_delay = -1;

    function automatic logic [31:0] memHash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    function int pickDelay();
        if (fixed_delay >= 0) return fixed_delay;
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    assign m_dat_i = memHash(m_adr_o) ^ mem_seed;
    assign m_ack_i = m_cyc_o & m_stb_o & (wait_cnt >= cur_delay);

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt  <= 0;
            cur_delay <= 0;
        end else if (m_ack_i) begin
            wait_cnt  <= 0;
            cur_delay <= pickDelay();
        end else if (m_cyc_o && m_stb_o) begin
            wait_cnt  <= wait_cnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] expStat();
        return {1'b0, 1'b0, wrap_m, half_m, 12'd0, 16'(pos_m)};
    endfunction

    // Word-level monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            hold_valid = 1'b0;
            rd_valid   = 1'b0;
        end else begin
            if (m_cyc_o) cyc_cycles++;
            if (m_cyc_o && m_stb_o) begin
                checkOutput("m_sel", {28'd0, m_sel_o}, 32'h0000_000F);
                if (hold_valid) begin
                    checkOutput("hold_adr", m_adr_o, hold_adr);
                    checkOutput("hold_we", {31'd0, m_we_o}, {31'd0, hold_we});
                end
                if (m_ack_i) begin
                    hold_valid = 1'b0;
                    if (!m_we_o) begin
                        checkOutput("rd_adr", m_adr_o, base_m + 32'(pos_m * 4));
                        if (m_adr_o == base_m && last_rd_adr == base_m + 32'h2EDC) wrap_seen++;
                        last_rd_adr = m_adr_o;
                        rd_data_m   = memHash(m_adr_o) ^ mem_seed;
                        rd_valid    = 1'b1;
                    end else begin
                        checkOutput("wr_adr", m_adr_o, I2S_ADDR);
                        checkOutput("wr_after_rd", {31'd0, rd_valid}, 32'd1);
                        checkOutput("wr_dat", m_dat_o, rd_data_m);
                        if (pos_m == len_m - 1) wrap_m = 1'b1;
                        if (pos_m == len_m / 2 - 1) half_m = 1'b1;
                        pos_m    = (pos_m + 1) % len_m;
                        rd_valid = 1'b0;
                        wr_count++;
                    end
                end else begin
                    hold_valid = 1'b1;
                    hold_adr   = m_adr_o;
                    hold_we    = m_we_o;
                end
            end else if (hold_valid) begin
                checkOutput("stb_held", {31'd0, m_stb_o}, 32'd1);
                hold_valid = 1'b0;
            end
        end
    end

    task automatic updateModel(input logic [1:0] adr, input logic [31:0] dat);
        case (adr)
            A_CTRL: begin
                if (dat[0] && !ctrl_m[0]) pos_m = 0;
                ctrl_m = dat[2:0];
            end
            A_BASE: base_m = {dat[31:2], 2'b00};
            A_LEN:  len_m  = int'(dat[15:0]);
            default: begin
                if (dat[29]) wrap_m = 1'b0;
                if (dat[28]) half_m = 1'b0;
            end
        endcase
    endtask

    // One slave access; returns the read data captured in the ack cycle.
    task automatic applyStimulus(input logic [1:0] adr, input logic we,
                                 input logic [31:0] dat, output logic [31:0] rdat);
        logic ok;
        ok = 1'b0;
        @(posedge clk_i); #1;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_adr_i = adr;
        s_we_i  = we;
        s_dat_i = dat;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (s_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("s_ack_seen", {31'd0, ok}, 32'd1);
        rdat = s_dat_o;
        if (we) updateModel(adr, dat);
        @(posedge clk_i); #1;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
    endtask

    task automatic cpuWrite(input logic [1:0] adr, input logic [31:0] dat);
        logic [31:0] unused;
        applyStimulus(adr, 1'b1, dat, unused);
    endtask

    task automatic cpuRead(input logic [1:0] adr, output logic [31:0] dat);
        applyStimulus(adr, 1'b0, 32'd0, dat);
    endtask

    task automatic waitIdle(input int budget);
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 8 && n < budget) begin
            @(negedge clk_i);
            n++;
            if (m_cyc_o) quiet = 0;
            else         quiet++;
        end
        checkOutput("reached_idle", {31'd0, quiet >= 8}, 32'd1);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [1:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [31:0] exp;
        int          gap;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          wr0;
        int          cyc0;
        int          wr_dis;
        int          n;

        mem_seed = $urandom;

        vecs[0]  = '{A_CTRL, 1'b0, 32'd0,          32'd0,          0};
        vecs[1]  = '{A_BASE, 1'b0, 32'd0,          32'd0,          0};
        vecs[2]  = '{A_LEN,  1'b0, 32'd0,          32'd0,          0};
        vecs[3]  = '{A_STAT, 1'b0, 32'd0,          32'd0,          0};
        vecs[4]  = '{A_BASE, 1'b1, 32'h0000_1003,  32'd0,          0};
        vecs[5]  = '{A_BASE, 1'b0, 32'd0,          32'h0000_1000,  0};
        vecs[6]  = '{A_LEN,  1'b1, 32'hABCD_0000,  32'd0,          0};
        vecs[7]  = '{A_LEN,  1'b0, 32'd0,          32'd0,          0};
        vecs[8]  = '{A_CTRL, 1'b1, 32'hFFFF_FFF9,  32'd0,          20};
        vecs[9]  = '{A_CTRL, 1'b0, 32'd0,          32'h0000_0001,  0};
        vecs[10] = '{A_STAT, 1'b0, 32'd0,          32'd0,          0};
        vecs[11] = '{A_CTRL, 1'b1, 32'd0,          32'd0,          0};
        vecs[12] = '{A_LEN,  1'b1, 32'h0001_2345,  32'd0,          0};
        vecs[13] = '{A_LEN,  1'b0, 32'd0,          32'h0000_2345,  0};
        vecs[14] = '{A_CTRL, 1'b1, 32'h0000_0006,  32'd0,          0};
        vecs[15] = '{A_CTRL, 1'b0, 32'd0,          32'h0000_0006,  0};
        vecs[16] = '{A_CTRL, 1'b1, 32'd0,          32'd0,          0};

        waitCycles(3);
        rst_i = 1'b1;
        waitCycles(2);

        // Reset values, register masking, and LEN==0 with en set
        cyc_cycles = 0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].adr, vecs[i].we, vecs[i].dat, rd);
            if (!vecs[i].we) checkOutput($sformatf("vec%0d", i), rd, vecs[i].exp);
            if (vecs[i].gap > 0) waitCycles(vecs[i].gap);
        end
        checkOutput("len0_no_cycle", 32'(cyc_cycles), 32'd0);

        // Prime: two bursts from BASE 0x1000 over an 8192-word ring
        cpuWrite(A_BASE, 32'h0000_1000);
        cpuWrite(A_LEN, 32'd8192);
        wr0 = wr_count;
        cpuWrite(A_CTRL, 32'd1);
        waitIdle(30000);
        checkOutput("prime_words", 32'(wr_count - wr0), 32'd4096);
        cpuRead(A_STAT, rd);
        checkOutput("prime_pos", {16'd0, rd[15:0]}, 32'd4096);
        checkOutput("prime_stat", rd, expStat());

        // Refill: one edge gives one burst; a held level does not retrigger
        wr0 = wr_count;
        req_i = 1'b1;
        waitIdle(15000);
        cyc0 = cyc_cycles;
        waitCycles(40);
        checkOutput("refill_words", 32'(wr_count - wr0), 32'd2048);
        checkOutput("no_retrigger", 32'(cyc_cycles - cyc0), 32'd0);
        cpuRead(A_STAT, rd);
        checkOutput("refill_pos", {16'd0, rd[15:0]}, 32'd6144);
        req_i = 1'b0;
        waitCycles(3);

        // Saturation: one edge starts a burst, and four more edges during it
        // queue only three further bursts
        wr0 = wr_count;
        req_i = 1'b1;
        n = 0;
        while (!m_cyc_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("cap_started", {31'd0, m_cyc_o}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            waitCycles(int'($urandom_range(2, 5)));
            req_i = 1'b0;
            waitCycles(int'($urandom_range(2, 5)));
            req_i = 1'b1;
        end
        waitCycles(3);
        req_i = 1'b0;
        waitIdle(60000);
        checkOutput("cap_words", 32'(wr_count - wr0), 32'(4 * BURST));
        cpuRead(A_STAT, rd);
        checkOutput("cap_stat", rd, expStat());
        checkOutput("cap_wrap_flag", {31'd0, rd[29]}, 32'd1);
        checkOutput("cap_irq_masked", {31'd0, irq_o}, 32'd0);

        // Wrap: a 3000-word ring with ie_wrap set
        cpuWrite(A_CTRL, 32'd0);
        cpuWrite(A_STAT, 32'h3000_0000);
        cpuRead(A_STAT, rd);
        checkOutput("flags_cleared", rd, expStat());
        cpuWrite(A_BASE, 32'h0000_2000);
        cpuWrite(A_LEN, 32'd3000);
        wrap_seen = 0;
        wr0 = wr_count;
        cpuWrite(A_CTRL, 32'd5);
        waitIdle(30000);
        checkOutput("wrap_words", 32'(wr_count - wr0), 32'd4096);
        checkOutput("wrap_addr_seen", 32'(wrap_seen), 32'd1);
        cpuRead(A_STAT, rd);
        checkOutput("wrap_stat", rd, expStat());
        checkOutput("wrap_pos", {16'd0, rd[15:0]}, 32'd1096);
        checkOutput("wrap_irq", {31'd0, irq_o}, 32'd1);
        cpuWrite(A_STAT, 32'h2000_0000);
        waitCycles(2);
        checkOutput("wrap_irq_cleared", {31'd0, irq_o}, 32'd0);
        cpuRead(A_STAT, rd);
        checkOutput("wrap_stat_cleared", rd, expStat());

        // Disable during a read whose ack is delayed 5 cycles
        cpuWrite(A_CTRL, 32'd0);
        fixed_delay = 5;
        wr0 = wr_count;
        cpuWrite(A_CTRL, 32'd1);
        n = 0;
        while (!(m_cyc_o && !m_we_o && wait_cnt == 0 && cur_delay == 5 && wr_count - wr0 >= 3)
               && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("dis_in_rd", {31'd0, m_cyc_o & ~m_we_o}, 32'd1);
        wr_dis = wr_count;
        cpuWrite(A_CTRL, 32'd0);
        waitIdle(2000);
        checkOutput("dis_no_write", 32'(wr_count - wr_dis), 32'd0);
        cpuRead(A_STAT, rd);
        checkOutput("dis_busy", {31'd0, rd[31]}, 32'd0);
        checkOutput("dis_stat", rd, expStat());
        cyc0 = cyc_cycles;
        req_i = 1'b1;
        waitCycles(40);
        req_i = 1'b0;
        checkOutput("dis_quiet", 32'(cyc_cycles - cyc0), 32'd0);

        // Asynchronous reset while a read is outstanding
        fixed_delay = 100;
        cpuWrite(A_BASE, 32'h0000_3000);
        cpuWrite(A_LEN, 32'd16);
        cpuWrite(A_CTRL, 32'd7);
        n = 0;
        while (!(m_cyc_o && !m_we_o) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("rst_in_rd", {31'd0, m_cyc_o & ~m_we_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        checkOutput("rst_m_cyc", {31'd0, m_cyc_o}, 32'd0);
        checkOutput("rst_m_stb", {31'd0, m_stb_o}, 32'd0);
        checkOutput("rst_m_we", {31'd0, m_we_o}, 32'd0);
        checkOutput("rst_m_adr", m_adr_o, 32'd0);
        checkOutput("rst_m_dat", m_dat_o, 32'd0);
        checkOutput("rst_m_sel", {28'd0, m_sel_o}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
        checkOutput("rst_s_ack", {31'd0, s_ack_o}, 32'd0);
        waitCycles(3);
        rst_i = 1'b1;
        fixed_delay = -1;
        cpuRead(A_STAT, rd);
        checkOutput("rst_stat", rd, 32'd0);
        cpuRead(A_CTRL, rd);
        checkOutput("rst_ctrl", rd, 32'd0);
        cpuRead(A_LEN, rd);
        checkOutput("rst_len", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
